// File: rtl/alu_serial.sv
// Parametrised bit-serial ALU: one operand bit per clock, LSB first, with a
// registered carry and a start/busy/done handshake.
module alu_serial #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [WIDTH:0]   out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   out_q, out_d;
  logic             done_q, done_d;

  logic a0, b0, b_eff, sum, cout, r, arith;

  always_comb begin
    a0    = a_q[0];
    b0    = b_q[0];
    arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    // SUB is a + ~b + 1: invert b here, the +1 is the preset carry
    b_eff = (op_q == OP_SUB) ? ~b0 : b0;
    sum   = a0 ^ b_eff ^ carry_q;
    cout  = (a0 & b_eff) | (a0 & carry_q) | (b_eff & carry_q);
    case (op_q)
      OP_ADD, OP_SUB: r = sum;
      OP_AND:         r = a0 & b0;
      OP_OR:          r = a0 | b0;
      OP_XOR:         r = a0 ^ b0;
      OP_XNOR:        r = ~(a0 ^ b0);
      OP_PASSA:       r = a0;
      default:        r = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    count_d = count_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          op_d    = op;
          res_d   = '0;
          count_d = '0;
          carry_d = (op == OP_SUB);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {r, res_q[WIDTH-1:1]};
        if (arith) carry_d = cout;
        if (count_q == CW'(WIDTH - 1)) begin
          count_d = '0;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        out_d   = {arith & carry_q, res_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign count = count_q;
  assign out   = out_q;

endmodule
